// File: rtl/inst_mem_resp_if.sv
// Fetch-side handshake between the instruction fetch unit and the instruction memory responder.
interface inst_mem_resp_if #(
  parameter int XLEN = 32
);
  logic            inst_ce_i;
  logic [XLEN-1:0] inst_addr_i;
  logic [XLEN-1:0] inst_o;
  logic            inst_valid_o;
  logic            busy_o;
  logic            misalign_o;

  modport master (
    output inst_ce_i,
    output inst_addr_i,
    input  inst_o,
    input  inst_valid_o,
    input  busy_o,
    input  misalign_o
  );

  modport slave (
    input  inst_ce_i,
    input  inst_addr_i,
    output inst_o,
    output inst_valid_o,
    output busy_o,
    output misalign_o
  );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: word RAM with a side load port, answering fetch requests
// after a fixed number of wait states through a small IDLE/WAIT/RESP state machine.
module inst_mem_resp #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_LOG2  = 10,
  parameter int              WAIT_CYCLES = 1,
  parameter logic [XLEN-1:0] RESET_INST  = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_mem_resp_if.slave   fetch,
  input  logic             load_we_i,
  input  logic [XLEN-1:0]  load_addr_i,
  input  logic [XLEN-1:0]  load_data_i
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gen_bad_wait
    $error("inst_mem_resp: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [3:0]              count;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic                    lat_mis;
  logic [XLEN-1:0]         inst_q;
  logic                    valid_q;
  logic                    misalign_q;

  logic [XLEN-1:0]         mem [0:DEPTH-1];

  logic                    busy;
  logic                    accept;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    req_mis;
  logic [DEPTH_LOG2-1:0]   load_idx;
  logic                    enter_resp;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    rd_mis;
  logic [XLEN-1:0]         rd_word;
  logic                    unused_addr_bits;

  assign busy     = (state == WAIT);
  assign accept   = fetch.inst_ce_i && !busy;
  assign req_idx  = fetch.inst_addr_i[DEPTH_LOG2+1:2];
  assign req_mis  = |fetch.inst_addr_i[1:0];
  assign load_idx = load_addr_i[DEPTH_LOG2+1:2];

  assign unused_addr_bits = ^{fetch.inst_addr_i[XLEN-1:DEPTH_LOG2+2],
                              load_addr_i[XLEN-1:DEPTH_LOG2+2], load_addr_i[1:0]};

  // With no wait states the response is captured on the accepting edge itself, so the
  // read uses the incoming request; otherwise it uses the address latched at acceptance.
  always_comb begin
    enter_resp = 1'b0;
    rd_idx     = lat_idx;
    rd_mis     = lat_mis;
    if (WAIT_CYCLES == 0) begin
      enter_resp = accept;
      rd_idx     = req_idx;
      rd_mis     = req_mis;
    end else begin
      enter_resp = (state == WAIT) && (count == 4'd0);
    end
  end

  // A load landing on the word being responded to wins, so the response sees the new data.
  assign rd_word = (load_we_i && (load_idx == rd_idx)) ? load_data_i : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem[load_idx] <= load_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 4'd0;
      lat_idx    <= '0;
      lat_mis    <= 1'b0;
      inst_q     <= RESET_INST;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            lat_idx <= req_idx;
            lat_mis <= req_mis;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= WAIT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        valid_q    <= 1'b1;
        misalign_q <= rd_mis;
        inst_q     <= rd_mis ? RESET_INST : rd_word;
      end
    end
  end

  assign fetch.inst_o       = inst_q;
  assign fetch.inst_valid_o = valid_q;
  assign fetch.misalign_o   = misalign_q;
  assign fetch.busy_o       = busy;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: four responders with 0..3 wait states share one load port;
// a scoreboard queue holds each expected response with the cycle it is due.
module tb_inst_mem_resp;

  logic        clk;
  logic        rst_n;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        ce        [4];
  logic [31:0] addr      [4];
  logic [31:0] resp_inst [4];
  logic        valid     [4];
  logic        busy      [4];
  logic        mis       [4];

  int testCount = 0;
  int failCount = 0;
  int cycle     = 0;

  typedef struct {
    int          dut;
    logic [31:0] inst;
    logic        mis;
    int          due;
  } sbEntry_t;

  sbEntry_t sbQueue[$];

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    inst_mem_resp_if #(.XLEN(32)) fif ();
    assign fif.inst_ce_i   = ce[g];
    assign fif.inst_addr_i = addr[g];
    assign resp_inst[g]    = fif.inst_o;
    assign valid[g]        = fif.inst_valid_o;
    assign busy[g]         = fif.busy_o;
    assign mis[g]          = fif.misalign_o;

    inst_mem_resp #(.WAIT_CYCLES(g)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch       (fif),
      .load_we_i   (load_we),
      .load_addr_i (load_addr),
      .load_data_i (load_data)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation, including its due cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (valid[d] === 1'b1) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_valid", 32'(sbQueue.size()), 32'd1);
        end else begin
          sbEntry_t e;
          e = sbQueue.pop_front();
          checkOutput("resp_dut", 32'(d), 32'(e.dut));
          checkOutput("resp_inst", resp_inst[d], e.inst);
          checkOutput("resp_misalign", {31'd0, mis[d]}, {31'd0, e.mis});
          checkOutput("resp_cycle", 32'(cycle), 32'(e.due));
        end
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1;
    load_we   = 1'b0;
  endtask

  // Drives one request; the accepting edge is the next one, so the response is due W cycles later.
  task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] expInst,
                               input logic expMis, input bit keep);
    sbEntry_t e;
    ce[d]   = 1'b1;
    addr[d] = a;
    e.dut   = d;
    e.inst  = expInst;
    e.mis   = expMis;
    e.due   = cycle + 1 + d;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) ce[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] words [4];
    words = '{32'h11, 32'h22, 32'h33, 32'h44};

    rst_n     = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int d = 0; d < 4; d++) begin
      ce[d]   = 1'b0;
      addr[d] = '0;
    end
    idleCycles(3);
    rst_n = 1'b1;
    idleCycles(1);

    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checkOutput("reset_inst", resp_inst[d], 32'h00000013);
      checkOutput("reset_valid", {31'd0, valid[d]}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy[d]}, 32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) loadWord(32'(i * 4), words[i]);

    // One wait state: busy for exactly the cycle between acceptance and response.
    applyStimulus(1, 32'h0, 32'h11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("busy_wait1", {31'd0, busy[1]}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("busy_resp1", {31'd0, busy[1]}, 32'd0);
    idleCycles(3);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'(i * 4), words[i], 1'b0, i < 3);
      @(negedge clk);
      checkOutput("busy_stream0", {31'd0, busy[0]}, 32'd0);
    end
    idleCycles(3);

    applyStimulus(1, 32'h6, 32'h00000013, 1'b1, 1'b0);
    idleCycles(3);
    applyStimulus(1, 32'h4, 32'h22, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(1, 32'h1004, 32'h22, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(0, 32'h7, 32'h00000013, 1'b1, 1'b0);
    idleCycles(2);

    // Load lands on the very edge that enters RESP for the two-wait-state responder.
    applyStimulus(2, 32'h8, 32'hDEAD, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    load_we   = 1'b1;
    load_addr = 32'h8;
    load_data = 32'hDEAD;
    @(posedge clk);
    #1;
    load_we = 1'b0;
    idleCycles(3);

    applyStimulus(3, 32'hC, 32'h44, 1'b0, 1'b0);
    addr[3] = 32'h0;
    @(posedge clk);
    #1;
    addr[3] = 32'h8;
    @(posedge clk);
    #1;
    addr[3] = 32'h4;
    idleCycles(4);

    // Reset in the middle of a wait must drop the request with no response.
    ce[3]   = 1'b1;
    addr[3] = 32'h4;
    @(posedge clk);
    #1;
    ce[3] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mid_valid", {31'd0, valid[3]}, 32'd0);
    checkOutput("rst_mid_inst", resp_inst[3], 32'h00000013);
    checkOutput("rst_mid_busy", {31'd0, busy[3]}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(6);

    applyStimulus(3, 32'h0, 32'h11, 1'b0, 1'b0);
    idleCycles(6);

    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
